// File: rtl/cpu_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_sequencer
//
// Run-control and instruction-feed block for the 8-bit single-cycle core.
// Holds the instruction memory (written through a byte-load port while the core
// is halted), presents imem[pc] combinationally, and gates core execution with a
// per-cycle enable under RUN / STEP / HALT / core-reset commands plus a single
// PC breakpoint. Counts retired instructions for the debug console.
//
// Ports:
//   clock, reset        system clock; asynchronous active-high reset
//   cmd_valid/ready     command handshake (transfer when both high at the edge)
//   cmd_op, cmd_arg     0 NOP, 1 RUN, 2 STEP, 3 HALT, 4 SET_BP, 5 CLR_BP,
//                       6 CPU_RST, 7 reserved (NOP); cmd_arg = breakpoint addr
//   load_valid/ready    imem byte write; ready only while HALTED
//   load_addr/data      imem write address / data
//   pc                  current core PC
//   instruction         imem[pc], combinational
//   cpu_en              core advances at an edge where this is 1
//   cpu_reset           synchronous reset pulse to the core (RST_CYCLES long)
//   run_state           0 HALTED, 1 RUN, 2 STEP, 3 CPURST
//   bp_hit              sticky flag: a breakpoint stopped RUN
//   retired             16-bit wrapping count of cycles with cpu_en = 1
// -----------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int IMEM_DEPTH = 256,
  parameter int RST_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [7:0]  cmd_arg,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [7:0]  load_addr,
  input  logic [7:0]  load_data,
  input  logic [7:0]  pc,
  output logic [7:0]  instruction,
  output logic        cpu_en,
  output logic        cpu_reset,
  output logic [1:0]  run_state,
  output logic        bp_hit,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_CPURST = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP     = 3'd0,
    OP_RUN     = 3'd1,
    OP_STEP    = 3'd2,
    OP_HALT    = 3'd3,
    OP_SET_BP  = 3'd4,
    OP_CLR_BP  = 3'd5,
    OP_CPU_RST = 3'd6,
    OP_RSVD    = 3'd7
  } op_t;

  localparam int                CNT_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RST_CYCLES - 1);

  state_t           state;
  op_t              op;
  logic             cmd_fire;
  logic             bp_en;
  logic [7:0]       bp_addr;
  logic             skip_bp;
  logic             bp_match;
  logic [CNT_W-1:0] rst_cnt;
  logic [7:0]       imem [IMEM_DEPTH];

  assign op         = op_t'(cmd_op);
  assign cmd_ready  = (state != ST_CPURST);
  assign load_ready = (state == ST_HALTED);
  assign cmd_fire   = cmd_valid && cmd_ready;
  assign run_state  = state;

  // skip_bp masks the match for the first RUN cycle so that resuming at the
  // breakpoint PC executes that instruction instead of stopping again.
  assign bp_match = bp_en && (pc == bp_addr) && !skip_bp;

  // Zero-latency stop: the matching cycle itself already has cpu_en low.
  assign cpu_en = (state == ST_STEP) || ((state == ST_RUN) && !bp_match);

  assign instruction = imem[pc];

  // NOTE: the instruction memory has no reset branch -- its contents survive
  // reset by design, and leaving it out keeps it mappable onto RAM.
  always_ff @(posedge clock) begin
    if (load_valid && load_ready) begin
      imem[load_addr] <= load_data;
    end
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples pre-edge values; later assignments in the block override
  // earlier ones (e.g. the retired clear on CPU_RST wins over the increment).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_HALTED;
      cpu_reset <= 1'b0;
      bp_hit    <= 1'b0;
      retired   <= 16'd0;
      bp_en     <= 1'b0;
      bp_addr   <= 8'd0;
      skip_bp   <= 1'b0;
      rst_cnt   <= '0;
    end else begin
      if (cpu_en) begin
        retired <= retired + 16'd1;
      end

      // Breakpoint programming is accepted in every state that takes commands.
      if (cmd_fire && op == OP_SET_BP) begin
        bp_addr <= cmd_arg;
        bp_en   <= 1'b1;
      end
      if (cmd_fire && op == OP_CLR_BP) begin
        bp_en <= 1'b0;
      end

      case (state)
        ST_HALTED: begin
          if (cmd_fire) begin
            case (op)
              OP_RUN: begin
                state   <= ST_RUN;
                skip_bp <= 1'b1;
                bp_hit  <= 1'b0;
              end
              OP_STEP: begin
                state  <= ST_STEP;
                bp_hit <= 1'b0;
              end
              OP_CPU_RST: begin
                state     <= ST_CPURST;
                cpu_reset <= 1'b1;
                rst_cnt   <= '0;
                retired   <= 16'd0;
              end
              default: ;
            endcase
          end
        end

        ST_RUN: begin
          skip_bp <= 1'b0;
          // A breakpoint match takes priority over a simultaneous HALT.
          if (bp_match) begin
            state  <= ST_HALTED;
            bp_hit <= 1'b1;
          end else if (cmd_fire && op == OP_HALT) begin
            state <= ST_HALTED;
          end
        end

        ST_STEP: begin
          state <= ST_HALTED;
        end

        ST_CPURST: begin
          if (rst_cnt == RST_LAST) begin
            state     <= ST_HALTED;
            cpu_reset <= 1'b0;
          end else begin
            rst_cnt <= rst_cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cpu_sequencer
//
// Directed bench for cpu_sequencer. A vector table covers imem loading, STEP,
// simultaneous load+command and no-op commands; hand-written sequences cover
// core reset, breakpoints, HALT timing, retired wrap and asynchronous reset.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_cpu_sequencer;

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_RUN     = 3'd1;
  localparam logic [2:0] OP_STEP    = 3'd2;
  localparam logic [2:0] OP_HALT    = 3'd3;
  localparam logic [2:0] OP_SET_BP  = 3'd4;
  localparam logic [2:0] OP_CLR_BP  = 3'd5;
  localparam logic [2:0] OP_CPU_RST = 3'd6;
  localparam logic [2:0] OP_RSVD    = 3'd7;

  logic        clock;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_arg;
  logic        load_valid;
  logic        load_ready;
  logic [7:0]  load_addr;
  logic [7:0]  load_data;
  logic [7:0]  pc;
  logic [7:0]  instruction;
  logic        cpu_en;
  logic        cpu_reset;
  logic [1:0]  run_state;
  logic        bp_hit;
  logic [15:0] retired;

  int n_cmp  = 0;
  int n_fail = 0;

  cpu_sequencer #(
    .IMEM_DEPTH(256),
    .RST_CYCLES(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .pc         (pc),
    .instruction(instruction),
    .cpu_en     (cpu_en),
    .cpu_reset  (cpu_reset),
    .run_state  (run_state),
    .bp_hit     (bp_hit),
    .retired    (retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        cv;
    logic [2:0]  op;
    logic [7:0]  arg;
    logic        lv;
    logic [7:0]  la;
    logic [7:0]  ld;
    logic [7:0]  pcv;
    logic        en;
    logic [1:0]  st;
    logic [15:0] ret;
    logic        chk_i;
    logic [7:0]  ins;
    logic        lr;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic en, input logic [1:0] st,
                      input logic [15:0] ret, input logic bh);
    check({tag, ".cpu_en"}, 16'(cpu_en), 16'(en));
    check({tag, ".run_state"}, 16'(run_state), 16'(st));
    check({tag, ".retired"}, retired, ret);
    check({tag, ".bp_hit"}, 16'(bp_hit), 16'(bh));
  endtask

  // Apply command inputs (no load) and move to the sampling point.
  task automatic drive(input logic cv, input logic [2:0] op, input logic [7:0] arg,
                       input logic [7:0] p);
    cmd_valid  = cv;
    cmd_op     = op;
    cmd_arg    = arg;
    load_valid = 1'b0;
    pc         = p;
    @(negedge clock);
  endtask

  task automatic adv();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // Table: loads, STEP, load+STEP, rejected load, no-op commands, SET_BP.
    //            cv op         arg    lv la     ld     pc     en st  ret chk ins    lr
    vecs[0]  = '{0, OP_NOP,     8'h00, 1, 8'h00, 8'h01, 8'h00, 0, 0, 0, 0, 8'h00, 1};
    vecs[1]  = '{0, OP_NOP,     8'h00, 1, 8'h01, 8'h12, 8'h00, 0, 0, 0, 1, 8'h01, 1};
    vecs[2]  = '{0, OP_NOP,     8'h00, 1, 8'h02, 8'h23, 8'h01, 0, 0, 0, 1, 8'h12, 1};
    vecs[3]  = '{0, OP_NOP,     8'h00, 1, 8'h03, 8'h30, 8'h02, 0, 0, 0, 1, 8'h23, 1};
    vecs[4]  = '{1, OP_STEP,    8'h00, 0, 8'h00, 8'h00, 8'h03, 0, 0, 0, 1, 8'h30, 1};
    vecs[5]  = '{0, OP_NOP,     8'h00, 0, 8'h00, 8'h00, 8'h00, 1, 2, 0, 1, 8'h01, 0};
    vecs[6]  = '{1, OP_STEP,    8'h00, 0, 8'h00, 8'h00, 8'h01, 0, 0, 1, 1, 8'h12, 1};
    vecs[7]  = '{0, OP_NOP,     8'h00, 0, 8'h00, 8'h00, 8'h01, 1, 2, 1, 1, 8'h12, 0};
    vecs[8]  = '{0, OP_NOP,     8'h00, 0, 8'h00, 8'h00, 8'h02, 0, 0, 2, 1, 8'h23, 1};
    vecs[9]  = '{1, OP_STEP,    8'h00, 1, 8'h02, 8'h55, 8'h02, 0, 0, 2, 1, 8'h23, 1};
    vecs[10] = '{0, OP_NOP,     8'h00, 1, 8'h03, 8'hFF, 8'h02, 1, 2, 2, 1, 8'h55, 0};
    vecs[11] = '{1, OP_HALT,    8'h00, 0, 8'h00, 8'h00, 8'h03, 0, 0, 3, 1, 8'h30, 1};
    vecs[12] = '{1, OP_RSVD,    8'h00, 0, 8'h00, 8'h00, 8'h03, 0, 0, 3, 1, 8'h30, 1};
    vecs[13] = '{1, OP_NOP,     8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 3, 1, 8'h01, 1};
    vecs[14] = '{1, OP_SET_BP,  8'h05, 0, 8'h00, 8'h00, 8'h00, 0, 0, 3, 1, 8'h01, 1};
    vecs[15] = '{0, OP_NOP,     8'h00, 0, 8'h00, 8'h00, 8'h00, 0, 0, 3, 1, 8'h01, 1};

    reset      = 1'b1;
    cmd_valid  = 1'b0;
    cmd_op     = OP_NOP;
    cmd_arg    = 8'h00;
    load_valid = 1'b0;
    load_addr  = 8'h00;
    load_data  = 8'h00;
    pc         = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    chk4("reset", 0, 0, 0, 0);
    check("reset.cpu_reset", 16'(cpu_reset), 16'd0);
    check("reset.cmd_ready", 16'(cmd_ready), 16'd1);
    check("reset.load_ready", 16'(load_ready), 16'd1);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      cmd_valid  = vecs[i].cv;
      cmd_op     = vecs[i].op;
      cmd_arg    = vecs[i].arg;
      load_valid = vecs[i].lv;
      load_addr  = vecs[i].la;
      load_data  = vecs[i].ld;
      pc         = vecs[i].pcv;
      @(negedge clock);
      check($sformatf("vec%0d.cpu_en", i), 16'(cpu_en), 16'(vecs[i].en));
      check($sformatf("vec%0d.run_state", i), 16'(run_state), 16'(vecs[i].st));
      check($sformatf("vec%0d.retired", i), retired, vecs[i].ret);
      check($sformatf("vec%0d.load_ready", i), 16'(load_ready), 16'(vecs[i].lr));
      if (vecs[i].chk_i) begin
        check($sformatf("vec%0d.instruction", i), 16'(instruction), 16'(vecs[i].ins));
      end
      @(posedge clock);
      #1;
    end

    // CPU_RST: two-cycle pulse, commands refused, retired cleared.
    drive(1, OP_CPU_RST, 8'h00, 8'h00);
    chk4("cpurst_accept", 0, 0, 3, 0);
    check("cpurst_accept.cpu_reset", 16'(cpu_reset), 16'd0);
    adv();
    for (int k = 0; k < 2; k++) begin
      drive(1, OP_RUN, 8'h00, 8'h00);
      chk4($sformatf("cpurst%0d", k), 0, 3, 0, 0);
      check($sformatf("cpurst%0d.cpu_reset", k), 16'(cpu_reset), 16'd1);
      check($sformatf("cpurst%0d.cmd_ready", k), 16'(cmd_ready), 16'd0);
      check($sformatf("cpurst%0d.load_ready", k), 16'(load_ready), 16'd0);
      adv();
    end
    drive(0, OP_NOP, 8'h00, 8'h00);
    chk4("cpurst_done", 0, 0, 0, 0);
    check("cpurst_done.cpu_reset", 16'(cpu_reset), 16'd0);
    check("cpurst_done.cmd_ready", 16'(cmd_ready), 16'd1);
    adv();

    // Breakpoint at 0x05 (set in the table): run from pc 0, stop at 5.
    drive(1, OP_RUN, 8'h00, 8'h00);
    chk4("bp_run_accept", 0, 0, 0, 0);
    adv();
    for (int p = 0; p < 5; p++) begin
      drive(0, OP_NOP, 8'h00, 8'(p));
      chk4($sformatf("bp_run%0d", p), 1, 1, 16'(p), 0);
      adv();
    end
    drive(0, OP_NOP, 8'h00, 8'h05);
    chk4("bp_stop", 0, 1, 5, 0);
    adv();
    drive(0, OP_NOP, 8'h00, 8'h05);
    chk4("bp_halted", 0, 0, 5, 1);
    check("bp_halted.load_ready", 16'(load_ready), 16'd1);
    adv();

    // Resume at the breakpoint PC: executes it, bp_hit clears.
    drive(1, OP_RUN, 8'h00, 8'h05);
    chk4("resume_accept", 0, 0, 5, 1);
    adv();
    drive(0, OP_NOP, 8'h00, 8'h05);
    chk4("resume_exec", 1, 1, 5, 0);
    adv();
    for (int i = 0; i < 10; i++) begin
      drive(0, OP_NOP, 8'h00, 8'(6 + i));
      chk4($sformatf("run10_%0d", i), 1, 1, 16'(6 + i), 0);
      check($sformatf("run10_%0d.load_ready", i), 16'(load_ready), 16'd0);
      adv();
    end
    drive(1, OP_HALT, 8'h00, 8'd16);
    chk4("halt_accept", 1, 1, 16, 0);
    check("halt_accept.load_ready", 16'(load_ready), 16'd0);
    adv();
    drive(0, OP_NOP, 8'h00, 8'd17);
    chk4("halt_after", 0, 0, 17, 0);
    check("halt_after.load_ready", 16'(load_ready), 16'd1);
    adv();

    // HALT coinciding with a breakpoint match: breakpoint wins.
    drive(1, OP_SET_BP, 8'd20, 8'd17);
    chk4("hb_setbp", 0, 0, 17, 0);
    adv();
    drive(1, OP_RUN, 8'h00, 8'd17);
    chk4("hb_run", 0, 0, 17, 0);
    adv();
    for (int p = 17; p < 20; p++) begin
      drive(0, OP_NOP, 8'h00, 8'(p));
      chk4($sformatf("hb_pc%0d", p), 1, 1, 16'(p), 0);
      adv();
    end
    drive(1, OP_HALT, 8'h00, 8'd20);
    chk4("hb_collide", 0, 1, 20, 0);
    adv();
    drive(0, OP_NOP, 8'h00, 8'd20);
    chk4("hb_after", 0, 0, 20, 1);
    adv();

    // SET_BP in RUN with cmd_arg == pc: matching starts next cycle.
    drive(1, OP_RUN, 8'h00, 8'd20);
    chk4("sb_run", 0, 0, 20, 1);
    adv();
    drive(0, OP_NOP, 8'h00, 8'd20);
    chk4("sb_skip", 1, 1, 20, 0);
    adv();
    drive(1, OP_SET_BP, 8'd21, 8'd21);
    chk4("sb_same", 1, 1, 21, 0);
    adv();
    drive(0, OP_NOP, 8'h00, 8'd21);
    chk4("sb_next", 0, 1, 22, 0);
    adv();
    drive(0, OP_NOP, 8'h00, 8'd21);
    chk4("sb_halted", 0, 0, 22, 1);
    adv();

    // CLR_BP: RUN at the old breakpoint PC no longer stops.
    drive(1, OP_CLR_BP, 8'h00, 8'd21);
    chk4("clr_bp", 0, 0, 22, 1);
    adv();
    drive(1, OP_RUN, 8'h00, 8'd21);
    chk4("clr_run", 0, 0, 22, 1);
    adv();
    drive(0, OP_NOP, 8'h00, 8'd21);
    chk4("clr_c0", 1, 1, 22, 0);
    adv();
    drive(0, OP_NOP, 8'h00, 8'd21);
    chk4("clr_c1", 1, 1, 23, 0);
    adv();
    drive(1, OP_HALT, 8'h00, 8'd22);
    chk4("clr_halt", 1, 1, 24, 0);
    adv();
    drive(0, OP_NOP, 8'h00, 8'd22);
    chk4("clr_halted", 0, 0, 25, 0);
    adv();

    // retired wrap: clear via CPU_RST, run up to 0xFFFE, then 3 more.
    drive(1, OP_CPU_RST, 8'h00, 8'h00);
    adv();
    drive(0, OP_NOP, 8'h00, 8'h00);
    adv();
    adv();
    drive(1, OP_RUN, 8'h00, 8'h00);
    chk4("wrap_pre", 0, 0, 0, 0);
    adv();
    drive(0, OP_NOP, 8'h00, 8'h00);
    repeat (65534) @(posedge clock);
    @(negedge clock);
    check("wrap_fffe.retired", retired, 16'hFFFE);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("wrap_0001.retired", retired, 16'h0001);
    adv();
    drive(1, OP_HALT, 8'h00, 8'h00);
    chk4("wrap_halt", 1, 1, 2, 0);
    adv();
    drive(0, OP_NOP, 8'h00, 8'h00);
    chk4("wrap_halted", 0, 0, 3, 0);
    adv();

    // Asynchronous reset mid-RUN with a breakpoint armed.
    drive(1, OP_SET_BP, 8'h30, 8'h2E);
    adv();
    drive(1, OP_RUN, 8'h00, 8'h2E);
    adv();
    drive(0, OP_NOP, 8'h00, 8'h2E);
    chk4("ar_run", 1, 1, 3, 0);
    adv();
    pc    = 8'h2F;
    reset = 1'b1;
    #1;
    chk4("ar_mid_run", 0, 0, 0, 0);
    check("ar_mid_run.cpu_reset", 16'(cpu_reset), 16'd0);
    #1;
    reset = 1'b0;
    adv();
    drive(1, OP_RUN, 8'h00, 8'h30);
    chk4("ar_resume", 0, 0, 0, 0);
    adv();
    drive(0, OP_NOP, 8'h00, 8'h30);
    chk4("ar_nobp0", 1, 1, 0, 0);
    adv();
    drive(0, OP_NOP, 8'h00, 8'h30);
    chk4("ar_nobp1", 1, 1, 1, 0);
    adv();
    drive(1, OP_HALT, 8'h00, 8'h30);
    adv();

    // Asynchronous reset mid-CPURST drops cpu_reset at once.
    drive(1, OP_CPU_RST, 8'h00, 8'h00);
    adv();
    check("arc_pulse.cpu_reset", 16'(cpu_reset), 16'd1);
    reset = 1'b1;
    #1;
    check("arc_drop.cpu_reset", 16'(cpu_reset), 16'd0);
    check("arc_drop.run_state", 16'(run_state), 16'd0);
    check("arc_drop.cmd_ready", 16'(cmd_ready), 16'd1);
    #1;
    reset = 1'b0;
    adv();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
